wavetable_reader: RTL and testbench

Reads a 512x16 waveform RAM as a free-running oscillator. Drives the RAM address, chip-enable and read-enable ports, and captures the returned words. Outputs one 16-bit sample per `sample_tick`. Sits between the waveform RAM and the synthesizer's mixer/DAC path, advancing a 24-bit phase accumulator by a programmable tuning word.

---
 rtl/wavetable_reader_if.sv | 22 ++
 rtl/wavetable_reader.sv | 171 +++++++++++++++++
 tb/tb_wavetable_reader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wavetable_reader_if.sv
// Waveform RAM port bundle: address, strobes and data between reader and RAM.
// Latency: none (wires only); the RAM returns ram_rdata one cycle after a read strobe.
// Backpressure: none; the RAM must accept every strobe.
// master = reader side (drives address/strobes), slave = RAM side (drives ram_rdata).
interface wavetable_reader_if;
   logic [8:0]  ram_addr;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;
   logic        ram_ce;
   logic        ram_re;
   logic        ram_we;

   modport master (
      output ram_addr, ram_wdata, ram_ce, ram_re, ram_we,
      input  ram_rdata
   );

   modport slave (
      input  ram_addr, ram_wdata, ram_ce, ram_re, ram_we,
      output ram_rdata
   );
endinterface

// File: rtl/wavetable_reader.sv
// Free-running wavetable oscillator: phase accumulator addresses a 512x16 RAM, one sample per tick.
// Latency: tick to sample_valid_o is 3 cycles, or 6 cycles with WT_INTERP_EN defined.
// Backpressure: none; ticks arriving while busy_o is high are dropped and do not advance phase.
// Ports: clk, rst (sync, active-high); sample_tick_i, enable_i, phase_clear_i, phase_inc_i
// control the oscillator; ram (wavetable_reader_if.master) is the RAM port;
// sample_out_o / sample_valid_o / busy_o are the sample stream and status.
// Optional macro WT_INTERP_EN: linear interpolation between adjacent table entries.
module wavetable_reader #(
   parameter int PHASE_W = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sample_tick_i,
   input  logic               enable_i,
   input  logic               phase_clear_i,
   input  logic [PHASE_W-1:0] phase_inc_i,
   wavetable_reader_if.master ram,
   output logic [15:0]        sample_out_o,
   output logic               sample_valid_o,
   output logic               busy_o
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD0  = 3'd1,
      CAP0 = 3'd2,
      OUT  = 3'd3
`ifdef WT_INTERP_EN
      ,
      RD1  = 3'd4,
      CAP1 = 3'd5,
      MUL  = 3'd6
`endif
   } state_t;

   state_t             state_q, state_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [8:0]         addr_q, addr_d;
   logic [15:0]        sample_q, sample_d;
   logic               accept;
   logic               rd_en;

`ifdef WT_INTERP_EN
   logic [7:0]         frac_q, frac_d;
   logic [15:0]        s0_q, s0_d;
   logic [15:0]        s1_q, s1_d;
   logic signed [16:0] diff;
   logic signed [25:0] prod;
   logic [15:0]        step;
   logic [15:0]        interp_res;

   // d = s1 - s0 fits in 17 signed bits; F is zero-extended so it multiplies as positive.
   // The arithmetic shift floors, keeping the result between s0 and s1 so the
   // 16-bit add below cannot wrap.
   assign diff       = $signed({1'b0, s1_q}) - $signed({1'b0, s0_q});
   assign prod       = diff * $signed({1'b0, frac_q});
   assign step       = 16'(prod >>> 8);
   assign interp_res = s0_q + step;
`endif

   assign accept = (state_q == IDLE) && sample_tick_i && enable_i;

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      addr_d   = addr_q;
      sample_d = sample_q;
      rd_en    = 1'b0;
`ifdef WT_INTERP_EN
      frac_d   = frac_q;
      s0_d     = s0_q;
      s1_d     = s1_q;
`endif

      // Clear wins over the accumulate; with a coinciding tick the read starts from phase 0.
      if (accept) begin
         if (phase_clear_i) begin
            addr_d  = '0;
            phase_d = phase_inc_i;
`ifdef WT_INTERP_EN
            frac_d  = '0;
`endif
         end else begin
            addr_d  = phase_q[PHASE_W-1 -: 9];
            phase_d = phase_q + phase_inc_i;
`ifdef WT_INTERP_EN
            frac_d  = phase_q[PHASE_W-10 -: 8];
`endif
         end
      end else if (phase_clear_i) begin
         phase_d = '0;
      end

      case (state_q)
         IDLE: begin
            if (accept) state_d = RD0;
         end
         RD0: begin
            rd_en   = 1'b1;
            state_d = CAP0;
         end
         CAP0: begin
            // addr_q is still A in this cycle; the RAM muxes its halves on ram_addr[8].
`ifdef WT_INTERP_EN
            s0_d    = ram.ram_rdata;
            addr_d  = addr_q + 9'd1;   // 511 wraps to 0
            state_d = RD1;
`else
            sample_d = ram.ram_rdata;
            state_d  = OUT;
`endif
         end
`ifdef WT_INTERP_EN
         RD1: begin
            rd_en   = 1'b1;
            state_d = CAP1;
         end
         CAP1: begin
            s1_d    = ram.ram_rdata;
            state_d = MUL;
         end
         MUL: begin
            sample_d = interp_res;
            state_d  = OUT;
         end
`endif
         OUT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         phase_q  <= '0;
         addr_q   <= '0;
         sample_q <= 16'h8000;
`ifdef WT_INTERP_EN
         frac_q   <= '0;
         s0_q     <= '0;
         s1_q     <= '0;
`endif
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         addr_q   <= addr_d;
         sample_q <= sample_d;
`ifdef WT_INTERP_EN
         frac_q   <= frac_d;
         s0_q     <= s0_d;
         s1_q     <= s1_d;
`endif
      end
   end

   assign ram.ram_addr  = addr_q;
   assign ram.ram_ce    = rd_en;
   assign ram.ram_re    = rd_en;
   assign ram.ram_we    = 1'b0;
   assign ram.ram_wdata = 16'h0000;

   // sample_q is loaded on the edge entering OUT, so it is already new while valid is high.
   assign sample_out_o   = sample_q;
   assign sample_valid_o = (state_q == OUT);
   assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_wavetable_reader.sv
// Directed bench for wavetable_reader with a 1-cycle registered RAM model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_wavetable_reader;

`ifdef WT_INTERP_EN
   localparam int  LAT    = 6;
   localparam bit  INTERP = 1'b1;
`else
   localparam int  LAT    = 3;
   localparam bit  INTERP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        sample_tick;
   logic        enable;
   logic        phase_clear;
   logic [23:0] phase_inc;
   logic [15:0] sample_out;
   logic        sample_valid;
   logic        busy;

   always #5 clk = ~clk;

   wavetable_reader_if ram_bus();

   wavetable_reader dut (
      .clk            (clk),
      .rst            (rst),
      .sample_tick_i  (sample_tick),
      .enable_i       (enable),
      .phase_clear_i  (phase_clear),
      .phase_inc_i    (phase_inc),
      .ram            (ram_bus),
      .sample_out_o   (sample_out),
      .sample_valid_o (sample_valid),
      .busy_o         (busy)
   );

   logic [15:0] mem [512];
   logic [8:0]  rd_q [$];
   int          hold_err = 0;
   logic        prev_rd = 1'b0;
   logic [8:0]  prev_addr = '0;
   int          vld_cnt = 0;
   int          vectors = 0;
   int          errors = 0;

   // RAM model: registered read, logs every read address, flags an address change
   // in the cycle right after a read strobe.
   always @(posedge clk) begin
      if (prev_rd && ram_bus.ram_addr !== prev_addr) hold_err <= hold_err + 1;
      prev_rd   <= ram_bus.ram_ce && ram_bus.ram_re;
      prev_addr <= ram_bus.ram_addr;
      if (ram_bus.ram_ce && ram_bus.ram_re) begin
         ram_bus.ram_rdata <= mem[ram_bus.ram_addr];
         rd_q.push_back(ram_bus.ram_addr);
      end
   end

   always @(negedge clk) if (sample_valid === 1'b1) vld_cnt++;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [8:0] rd_at(input int idx);
      logic [8:0] r;
      r = 9'bx;
      if (rd_q.size() > idx) r = rd_q[idx];
      return r;
   endfunction

   // One-cycle tick; returns cycles from the accepting edge to sample_valid (0 = timeout).
   task automatic do_tick(input logic [23:0] inc, input logic clr,
                          output int lat, output logic [15:0] smp, output int base);
      base        = rd_q.size();
      sample_tick = 1'b1;
      phase_inc   = inc;
      phase_clear = clr;
      @(posedge clk);
      #1;
      sample_tick = 1'b0;
      phase_clear = 1'b0;
      lat = 0;
      smp = 16'bx;
      for (int n = 1; n <= 20 && lat == 0; n++) begin
         if (sample_valid === 1'b1) begin
            lat = n;
            smp = sample_out;
         end else begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step(2);
      vectors++; if (sample_out !== 16'h8000) begin errors++; $display("FAIL reset_sample: got %h want 8000", sample_out); end
      vectors++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (ram_bus.ram_addr !== 9'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", ram_bus.ram_addr); end
      vectors++; if ({ram_bus.ram_ce, ram_bus.ram_re, ram_bus.ram_we} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b want 000", {ram_bus.ram_ce, ram_bus.ram_re, ram_bus.ram_we}); end
      vectors++; if (ram_bus.ram_wdata !== 16'h0000) begin errors++; $display("FAIL reset_wdata: got %h want 0000", ram_bus.ram_wdata); end
      rst = 1'b0;
      step(1);
   endtask

   task automatic test_linear_step;
      int lat, base;
      logic [15:0] smp;
      for (int k = 0; k < 3; k++) begin
         do_tick(24'h008000, 1'b0, lat, smp, base);
         vectors++; if (lat !== LAT) begin errors++; $display("FAIL lin_latency[%0d]: got %0d want %0d", k, lat, LAT); end
         vectors++; if (rd_at(base) !== 9'(k)) begin errors++; $display("FAIL lin_addr[%0d]: got %h want %h", k, rd_at(base), k); end
         vectors++; if (smp !== 16'(16'h1000 + k)) begin errors++; $display("FAIL lin_sample[%0d]: got %h want %h", k, smp, 16'h1000 + k); end
         if (INTERP) begin
            vectors++; if (rd_at(base + 1) !== 9'(k + 1)) begin errors++; $display("FAIL lin_addr1[%0d]: got %h want %h", k, rd_at(base + 1), k + 1); end
         end
         step(1);
         vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL lin_busy_fall[%0d]: got %b want 0", k, busy); end
         step(5);
      end
   endtask

   task automatic test_wrap;
      int lat, base;
      logic [15:0] smp;
      mem[511] = 16'h2000;
      // Clear with tick: reads address 0, then phase = FFC000 (A=511, F=80).
      do_tick(24'hFFC000, 1'b1, lat, smp, base);
      vectors++; if (rd_at(base) !== 9'd0) begin errors++; $display("FAIL clr_addr: got %h want 000", rd_at(base)); end
      vectors++; if (smp !== 16'h1000) begin errors++; $display("FAIL clr_sample: got %h want 1000", smp); end
      step(6);
      do_tick(24'h008000, 1'b0, lat, smp, base);
      vectors++; if (rd_at(base) !== 9'd511) begin errors++; $display("FAIL wrap_addr: got %h want 1ff", rd_at(base)); end
      vectors++; if (smp !== (INTERP ? 16'h1800 : 16'h2000)) begin errors++; $display("FAIL wrap_sample: got %h want %h", smp, INTERP ? 16'h1800 : 16'h2000); end
      if (INTERP) begin
         vectors++; if (rd_at(base + 1) !== 9'd0) begin errors++; $display("FAIL wrap_addr1: got %h want 000", rd_at(base + 1)); end
      end
      step(6);
      // Phase is now 004000: A=0, F=80; mem[0]=1000, mem[1]=1001 interpolate to 1000.
      do_tick(24'h008000, 1'b0, lat, smp, base);
      vectors++; if (rd_at(base) !== 9'd0) begin errors++; $display("FAIL wrap_next_addr: got %h want 000", rd_at(base)); end
      vectors++; if (smp !== 16'h1000) begin errors++; $display("FAIL wrap_next_sample: got %h want 1000", smp); end
      step(6);
      mem[511] = 16'h1000 + 16'd511;
   endtask

   task automatic test_zero_inc_interp;
      int lat, base;
      logic [15:0] smp;
      mem[5] = 16'h1000;
      mem[6] = 16'h2000;
      do_tick(24'h02C000, 1'b1, lat, smp, base);
      step(6);
      do_tick(24'h000000, 1'b0, lat, smp, base);
      vectors++; if (rd_at(base) !== 9'd5) begin errors++; $display("FAIL interp_up_addr: got %h want 005", rd_at(base)); end
      vectors++; if (smp !== (INTERP ? 16'h1800 : 16'h1000)) begin errors++; $display("FAIL interp_up_sample: got %h want %h", smp, INTERP ? 16'h1800 : 16'h1000); end
      step(6);
      mem[6] = 16'h0800;
      do_tick(24'h000000, 1'b0, lat, smp, base);
      vectors++; if (rd_at(base) !== 9'd5) begin errors++; $display("FAIL zero_inc_addr: got %h want 005", rd_at(base)); end
      vectors++; if (smp !== (INTERP ? 16'h0C00 : 16'h1000)) begin errors++; $display("FAIL interp_down_sample: got %h want %h", smp, INTERP ? 16'h0C00 : 16'h1000); end
      step(6);
      mem[5] = 16'h1005;
      mem[6] = 16'h1006;
   endtask

   task automatic test_overlap_enable;
      int lat, base, c0;
      logic [15:0] smp;
      do_tick(24'h008000, 1'b1, lat, smp, base);      // phase -> 008000
      step(6);
      c0 = vld_cnt;
      sample_tick = 1'b1;
      phase_inc   = 24'h008000;
      step(1);                                        // accepted: A=1, phase -> 010000
      phase_inc   = 24'h123456;
      step(2);                                        // ticks while busy are dropped
      sample_tick = 1'b0;
      step(10);
      vectors++; if (vld_cnt - c0 !== 1) begin errors++; $display("FAIL overlap_valid_count: got %0d want 1", vld_cnt - c0); end
      do_tick(24'h000000, 1'b0, lat, smp, base);
      vectors++; if (rd_at(base) !== 9'd2) begin errors++; $display("FAIL overlap_phase_addr: got %h want 002", rd_at(base)); end
      vectors++; if (smp !== 16'h1002) begin errors++; $display("FAIL overlap_sample: got %h want 1002", smp); end
      step(6);
      // Disabled tick is ignored.
      c0 = vld_cnt;
      base = rd_q.size();
      enable = 1'b0;
      sample_tick = 1'b1;
      step(1);
      sample_tick = 1'b0;
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL disabled_busy: got %b want 0", busy); end
      step(8);
      vectors++; if (vld_cnt - c0 !== 0) begin errors++; $display("FAIL disabled_valid_count: got %0d want 0", vld_cnt - c0); end
      // Enable dropping mid-read lets the sample finish; phase held at 010000.
      enable = 1'b1;
      sample_tick = 1'b1;
      step(1);
      sample_tick = 1'b0;
      enable = 1'b0;
      step(LAT + 3);
      vectors++; if (vld_cnt - c0 !== 1) begin errors++; $display("FAIL enable_drop_valid_count: got %0d want 1", vld_cnt - c0); end
      vectors++; if (rd_at(base) !== 9'd2) begin errors++; $display("FAIL enable_drop_addr: got %h want 002", rd_at(base)); end
      vectors++; if (sample_out !== 16'h1002) begin errors++; $display("FAIL enable_drop_sample: got %h want 1002", sample_out); end
      enable = 1'b1;
      step(2);
   endtask

   task automatic test_reset_mid;
      int lat, base, c0;
      logic [15:0] smp;
      c0 = vld_cnt;
      sample_tick = 1'b1;
      phase_inc   = 24'h008000;
      step(1);                                        // RD0
      sample_tick = 1'b0;
      step(1);                                        // CAP0
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      vectors++; if (sample_out !== 16'h8000) begin errors++; $display("FAIL rstmid_sample: got %h want 8000", sample_out); end
      step(8);
      vectors++; if (vld_cnt - c0 !== 0) begin errors++; $display("FAIL rstmid_valid_count: got %0d want 0", vld_cnt - c0); end
      do_tick(24'h008000, 1'b0, lat, smp, base);
      vectors++; if (lat !== LAT) begin errors++; $display("FAIL rstmid_latency: got %0d want %0d", lat, LAT); end
      vectors++; if (rd_at(base) !== 9'd0) begin errors++; $display("FAIL rstmid_addr: got %h want 000", rd_at(base)); end
      vectors++; if (smp !== 16'h1000) begin errors++; $display("FAIL rstmid_next_sample: got %h want 1000", smp); end
      step(6);
   endtask

   task automatic test_addr_hold;
      vectors++; if (hold_err !== 0) begin errors++; $display("FAIL addr_hold: got %0d changes want 0", hold_err); end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 16'h1000 + 16'(i);
      rst         = 1'b1;
      sample_tick = 1'b0;
      enable      = 1'b1;
      phase_clear = 1'b0;
      phase_inc   = '0;
      step(1);
      test_reset;
      test_linear_step;
      test_wrap;
      test_zero_inc_interp;
      test_overlap_enable;
      test_reset_mid;
      test_addr_hold;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
